// File: rtl/mem_copier.sv
`default_nettype none
// ============================================================================
// mem_copier : RAM-port initiator that copies a word range or fills it with
//              a constant, using a start/busy/done handshake.
// Revision   : 1.0
// ============================================================================
module mem_copier #(
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic                 in_mode,
  input  logic [ADDR_BITS-1:0] in_src_addr,
  input  logic [ADDR_BITS-1:0] in_dst_addr,
  input  logic [ADDR_BITS:0]   in_count,
  input  logic [WORD_BITS-1:0] in_fill_value,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_read_ena,
  output logic                 out_write_ena,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [WORD_BITS-1:0] out_data,
  input  logic [WORD_BITS-1:0] in_data
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_read  = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_write = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [ADDR_BITS:0] c_last_word = (ADDR_BITS + 1)'(1);

  logic [2:0]           r_state;
  logic [ADDR_BITS-1:0] r_src_ptr;
  logic [ADDR_BITS-1:0] r_dst_ptr;
  logic [ADDR_BITS:0]   r_remaining;
  logic                 r_mode;
  logic [WORD_BITS-1:0] r_fill_value;
  logic [WORD_BITS-1:0] r_buffer;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state      <= c_st_idle;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_remaining  <= '0;
      r_mode       <= 1'b0;
      r_fill_value <= '0;
      r_buffer     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_start) begin
            r_src_ptr    <= in_src_addr;
            r_dst_ptr    <= in_dst_addr;
            r_remaining  <= in_count;
            r_mode       <= in_mode;
            r_fill_value <= in_fill_value;
            if (in_count == '0)
              r_state <= c_st_done;
            else if (in_mode)
              r_state <= c_st_write;
            else
              r_state <= c_st_read;
          end
        end
        c_st_read:
          r_state <= c_st_wait;
        c_st_wait: begin
          r_buffer <= in_data;
          r_state  <= c_st_write;
        end
        c_st_write: begin
          r_dst_ptr   <= r_dst_ptr + ADDR_BITS'(1);
          r_remaining <= r_remaining - c_last_word;
          if (!r_mode)
            r_src_ptr <= r_src_ptr + ADDR_BITS'(1);
          if (r_remaining == c_last_word)
            r_state <= c_st_done;
          else if (r_mode)
            r_state <= c_st_write;
          else
            r_state <= c_st_read;
        end
        c_st_done:
          r_state <= c_st_idle;
        default:
          r_state <= c_st_idle;
      endcase
    end
  end

  // Outputs are also gated by reset so a write in flight is cut off at once.
  always_comb begin
    out_busy      = 1'b0;
    out_done      = 1'b0;
    out_read_ena  = 1'b0;
    out_write_ena = 1'b0;
    out_addr      = '0;
    out_data      = '0;
    if (!in_rst) begin
      out_busy = (r_state != c_st_idle);
      case (r_state)
        c_st_read: begin
          out_read_ena = 1'b1;
          out_addr     = r_src_ptr;
        end
        c_st_write: begin
          out_write_ena = 1'b1;
          out_addr      = r_dst_ptr;
          out_data      = r_mode ? r_fill_value : r_buffer;
        end
        c_st_done:
          out_done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copier.sv
`default_nettype none
// Bench for mem_copier: behavioural synchronous RAM, reference memory image and
// write/read scoreboards filled when each operation is launched.
module tb_mem_copier;

  localparam int ADDR_BITS = 3;
  localparam int WORD_BITS = 8;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic                 in_clk = 1'b0;
  logic                 in_rst = 1'b1;
  logic                 in_start = 1'b0;
  logic                 in_mode = 1'b0;
  logic [ADDR_BITS-1:0] in_src_addr = '0;
  logic [ADDR_BITS-1:0] in_dst_addr = '0;
  logic [ADDR_BITS:0]   in_count = '0;
  logic [WORD_BITS-1:0] in_fill_value = '0;
  logic                 out_busy, out_done, out_read_ena, out_write_ena;
  logic [ADDR_BITS-1:0] out_addr;
  logic [WORD_BITS-1:0] out_data;
  logic [WORD_BITS-1:0] in_data;

  logic [WORD_BITS-1:0] ram [DEPTH];
  logic [WORD_BITS-1:0] exp_mem [DEPTH];
  logic                 bd_we = 1'b0;
  logic [ADDR_BITS-1:0] bd_addr = '0;
  logic [WORD_BITS-1:0] bd_data = '0;

  logic [ADDR_BITS+WORD_BITS-1:0] wr_q [$];
  logic [ADDR_BITS-1:0]           rd_q [$];

  int vectors = 0;
  int errors  = 0;

  mem_copier #(.ADDR_BITS(ADDR_BITS), .WORD_BITS(WORD_BITS)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_mode(in_mode),
    .in_src_addr(in_src_addr), .in_dst_addr(in_dst_addr), .in_count(in_count),
    .in_fill_value(in_fill_value), .out_busy(out_busy), .out_done(out_done),
    .out_read_ena(out_read_ena), .out_write_ena(out_write_ena),
    .out_addr(out_addr), .out_data(out_data), .in_data(in_data)
  );

  always #5 in_clk = ~in_clk;

  // Synchronous RAM with registered read data and a bench backdoor write port.
  always @(posedge in_clk) begin
    if (bd_we)
      ram[bd_addr] <= bd_data;
    else if (out_write_ena)
      ram[out_addr] <= out_data;
    if (out_read_ena)
      in_data <= ram[out_addr];
  end

  task automatic preload(input logic [ADDR_BITS-1:0] a, input logic [WORD_BITS-1:0] d);
    @(negedge in_clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge in_clk);
    #1 bd_we = 1'b0;
    exp_mem[a] = d;
  endtask

  // Launches one operation and checks handshake timing, RAM traffic and the final image.
  task automatic run_op(input string name, input logic mode, input logic [ADDR_BITS-1:0] src,
                        input logic [ADDR_BITS-1:0] dst, input int count,
                        input logic [WORD_BITS-1:0] fill, input int poke_cycle);
    int exp_done;
    logic [ADDR_BITS-1:0] sa, da;
    logic [ADDR_BITS+WORD_BITS-1:0] wr;
    logic [ADDR_BITS-1:0] ra;
    wr_q.delete(); rd_q.delete();
    for (int i = 0; i < count; i++) begin
      sa = ADDR_BITS'(int'(src) + i);
      da = ADDR_BITS'(int'(dst) + i);
      if (!mode) rd_q.push_back(sa);
      exp_mem[da] = mode ? fill : exp_mem[sa];
      wr_q.push_back({da, exp_mem[da]});
    end
    exp_done = (count == 0) ? 1 : (mode ? count + 1 : 3 * count + 1);

    @(negedge in_clk);
    in_start = 1'b1; in_mode = mode; in_src_addr = src; in_dst_addr = dst;
    in_count = (ADDR_BITS + 1)'(count); in_fill_value = fill;
    @(posedge in_clk);
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge in_clk);
      in_start = 1'b0;
      if (c == poke_cycle) begin
        in_start = 1'b1; in_mode = ~mode; in_src_addr = 3'd5; in_dst_addr = 3'd0;
        in_count = 4'd2; in_fill_value = 8'hEE;
      end
      vectors++;
      if (out_busy !== (c <= exp_done)) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b expected %b", name, c, out_busy, c <= exp_done);
      end
      vectors++;
      if (out_done !== (c == exp_done)) begin
        errors++;
        $display("FAIL %s done cycle %0d got %b expected %b", name, c, out_done, c == exp_done);
      end
      if (out_read_ena) begin
        vectors++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL %s read cycle %0d got addr %0d expected no read", name, c, out_addr);
        end else begin
          ra = rd_q.pop_front();
          if (out_addr !== ra) begin
            errors++;
            $display("FAIL %s read_addr cycle %0d got %0d expected %0d", name, c, out_addr, ra);
          end
        end
      end
      if (out_write_ena) begin
        vectors++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL %s write cycle %0d got %0d:%h expected no write", name, c, out_addr, out_data);
        end else begin
          wr = wr_q.pop_front();
          if ({out_addr, out_data} !== wr) begin
            errors++;
            $display("FAIL %s write cycle %0d got %0d:%h expected %0d:%h", name, c,
                     out_addr, out_data, wr[ADDR_BITS+WORD_BITS-1:WORD_BITS], wr[WORD_BITS-1:0]);
          end
        end
      end
    end
    in_start = 1'b0;
    vectors++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover got %0d writes %0d reads expected 0 0", name, wr_q.size(), rd_q.size());
    end
    for (int a = 0; a < DEPTH; a++) begin
      vectors++;
      if (ram[a] !== exp_mem[a]) begin
        errors++;
        $display("FAIL %s ram[%0d] got %h expected %h", name, a, ram[a], exp_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    vectors++;
    if ({out_busy, out_done, out_read_ena, out_write_ena, out_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b%b%b%b %0d %h expected all 0", out_busy, out_done,
               out_read_ena, out_write_ena, out_addr, out_data);
    end
    in_rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) preload(ADDR_BITS'(a), 8'h00);
  endtask

  task automatic test_copy();
    for (int a = 0; a < 4; a++) preload(ADDR_BITS'(a), WORD_BITS'(8'h31 + a));
    run_op("copy", 1'b0, 3'd0, 3'd4, 4, 8'h00, 0);
  endtask

  task automatic test_fill();
    run_op("fill", 1'b1, 3'd0, 3'd2, 3, 8'hA5, 0);
  endtask

  task automatic test_wrap();
    preload(3'd6, 8'h66); preload(3'd7, 8'h77); preload(3'd0, 8'h10);
    run_op("wrap", 1'b0, 3'd6, 3'd1, 3, 8'h00, 0);
  endtask

  task automatic test_overlap_zero();
    preload(3'd0, 8'h11); preload(3'd1, 8'h22); preload(3'd2, 8'h33);
    run_op("overlap", 1'b0, 3'd0, 3'd1, 2, 8'h00, 0);
    run_op("zero", 1'b0, 3'd3, 3'd4, 0, 8'h00, 0);
  endtask

  task automatic test_full_range();
    run_op("full", 1'b1, 3'd0, 3'd5, 8, 8'hC3, 0);
  endtask

  task automatic test_busy_start();
    for (int a = 0; a < 4; a++) preload(ADDR_BITS'(a), WORD_BITS'(8'h40 + a));
    run_op("busy_start", 1'b0, 3'd0, 3'd4, 4, 8'h00, 2);
  endtask

  task automatic test_reset_mid();
    @(negedge in_clk);
    in_start = 1'b1; in_mode = 1'b1; in_dst_addr = 3'd0; in_count = 4'd8; in_fill_value = 8'h5A;
    @(posedge in_clk);
    @(negedge in_clk); in_start = 1'b0;
    repeat (2) @(negedge in_clk);
    vectors++;
    if (out_write_ena !== 1'b1 || out_addr !== 3'd2) begin
      errors++;
      $display("FAIL rst_mid pre got we=%b addr=%0d expected we=1 addr=2", out_write_ena, out_addr);
    end
    #1 in_rst = 1'b1;
    #1;
    vectors++;
    if ({out_write_ena, out_busy, out_done, out_read_ena, out_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid_drop got we=%b busy=%b done=%b re=%b addr=%0d data=%h expected all 0",
               out_write_ena, out_busy, out_done, out_read_ena, out_addr, out_data);
    end
    exp_mem[0] = 8'h5A; exp_mem[1] = 8'h5A;
    @(negedge in_clk); in_rst = 1'b0;
    @(negedge in_clk);
    vectors++;
    if (out_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle busy got %b expected 0", out_busy);
    end
    run_op("after_reset", 1'b1, 3'd0, 3'd6, 1, 8'h99, 0);
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_overlap_zero();
    test_full_range();
    test_busy_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
